// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, receive FSM state encoding and decoded-code payload.
package ps2_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BITCNT_W = 3;

  // Protocol prefixes
  localparam logic [BYTE_W-1:0] SC_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;

  // Game keys (make codes, set 2)
  localparam logic [BYTE_W-1:0] KEY_A     = 8'h1C;
  localparam logic [BYTE_W-1:0] KEY_D     = 8'h23;
  localparam logic [BYTE_W-1:0] KEY_J     = 8'h3B;
  localparam logic [BYTE_W-1:0] KEY_L     = 8'h4B;
  localparam logic [BYTE_W-1:0] KEY_ESC   = 8'h76;
  localparam logic [BYTE_W-1:0] KEY_SPACE = 8'h29;
  localparam logic [BYTE_W-1:0] KEY_1     = 8'h16;
  localparam logic [BYTE_W-1:0] KEY_2     = 8'h1E;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic              extended;
    logic [BYTE_W-1:0] code;
  } scan_code_t;

  // PS/2 uses odd parity over data + parity bit.
  function automatic logic frame_parity_ok(input logic [BYTE_W-1:0] data,
                                           input logic              parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes the PS/2 pins, deglitches ps2_clk and emits a one-cycle fall strobe.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_filt;
  logic             clk_filt_dly;
  logic [CNT_W-1:0] cnt;

  assign data_sync = dat_sync[1];

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Accept a new clock level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_filt <= 1'b1;
      cnt      <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered falling-edge strobe of the filtered clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_filt_dly <= 1'b1;
      fall         <= 1'b0;
    end else begin
      clk_filt_dly <= clk_filt;
      fall         <= clk_filt_dly & ~clk_filt;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes, drops break/extended prefixes, stretches done.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT    = 2500,
  parameter int unsigned DONE_HOLD  = 1600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] tasta,
  output logic       done,
  output logic       extended,
  output logic       frame_error
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(DONE_HOLD + 1);

  logic                fall;
  logic                data_sync;

  rx_state_t           state;
  rx_state_t           state_next;
  logic [BYTE_W-1:0]   shift_q;
  logic [BITCNT_W-1:0] bit_cnt;
  logic                parity_q;
  logic [TMO_W-1:0]    tmo_cnt;

  logic                timeout_c;
  logic                start_c;
  logic                shift_en_c;
  logic                parity_en_c;
  logic                stop_c;
  logic                byte_ok_c;
  logic                frame_err_c;

  logic                brk_q;
  logic                ext_q;
  logic                make_c;
  scan_code_t          code_q;
  logic [HOLD_W-1:0]   hold_cnt;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .fall      (fall),
    .data_sync (data_sync)
  );

  assign tasta    = code_q.code;
  assign extended = code_q.extended;

  // A fall in the same cycle restarts the idle count, so it wins over timeout.
  assign timeout_c = (state != RX_IDLE) && !fall && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Receive FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  // Receive FSM next-state logic, stepping on each filtered fall.
  always_comb begin
    state_next = state;
    if (timeout_c) begin
      state_next = RX_IDLE;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!data_sync) state_next = RX_DATA;
        RX_DATA:   if (bit_cnt == BITCNT_W'(BYTE_W - 1)) state_next = RX_PARITY;
        RX_PARITY: state_next = RX_STOP;
        RX_STOP:   state_next = RX_IDLE;
        default:   state_next = RX_IDLE;
      endcase
    end
  end

  // Receive FSM strobes and frame validation.
  always_comb begin
    start_c     = 1'b0;
    shift_en_c  = 1'b0;
    parity_en_c = 1'b0;
    stop_c      = 1'b0;
    if (fall) begin
      case (state)
        RX_IDLE:   start_c     = !data_sync;
        RX_DATA:   shift_en_c  = 1'b1;
        RX_PARITY: parity_en_c = 1'b1;
        RX_STOP:   stop_c      = 1'b1;
        default:   ;
      endcase
    end
    byte_ok_c   = stop_c && data_sync && frame_parity_ok(shift_q, parity_q);
    frame_err_c = (stop_c && !byte_ok_c) || timeout_c;
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
    end else begin
      if (start_c) begin
        bit_cnt <= '0;
      end else if (shift_en_c) begin
        shift_q <= {data_sync, shift_q[BYTE_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (parity_en_c) parity_q <= data_sync;
    end
  end

  // Mid-frame idle counter; restarts on every fall and is parked in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (fall || (state == RX_IDLE) || timeout_c) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A make code is any valid byte that is not a prefix and not part of a release.
  always_comb begin
    make_c = byte_ok_c && !brk_q && (shift_q != SC_BREAK) && (shift_q != SC_EXT);
  end

  // Decoder flags and output code register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      code_q      <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= frame_err_c;
      if (byte_ok_c) begin
        if (shift_q == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (shift_q == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (brk_q) begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end else begin
          code_q <= '{extended: ext_q, code: shift_q};
          ext_q  <= 1'b0;
        end
      end else if (stop_c) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  // Stretch done for DONE_HOLD cycles after each make code.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      done     <= 1'b0;
    end else if (make_c) begin
      hold_cnt <= HOLD_W'(DONE_HOLD);
      done     <= 1'b1;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - 1'b1;
      done     <= (hold_cnt != HOLD_W'(1));
    end
  end

endmodule
